rat_intr_ctrl: RTL and testbench
================================

RAT_INTR_CTRL -- requirements
Module: rat_intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (1..8).
REQ-002 Parameter GAP_CYCLES, default 4, minimum INTR-low cycles after an acknowledge (1..15).
REQ-003 CLK  input  1  system clock; the 50 MHz MCU clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 SRC  input  NUM_SRC  interrupt request lines, synchronous to CLK, rising-edge sensitive.
REQ-006 PORT_ID  input  8  MCU port address.
REQ-007 OUT_PORT  input  8  MCU write data.
REQ-008 IO_STRB  input  1  MCU write strobe; a write occurs on each CLK edge where it is 1.
REQ-009 IN_PORT  output  8  read data toward the wrapper input mux, combinational from PORT_ID.
REQ-010 INTR  output  1  registered interrupt request to the MCU.

Function
REQ-011 Port IDs: MASK_ID 8'h50 (R/W), STATUS_ID 8'h51 (R), VECTOR_ID 8'h52 (R), ACK_ID 8'h53 (W).
REQ-012 Register SRC once into src_q; edge[i] = SRC[i] & ~src_q[i]; pending[i] sets on the cycle after edge detection.
REQ-013 Write to MASK_ID loads mask <= OUT_PORT[NUM_SRC-1:0].
REQ-014 Write to ACK_ID clears pending bits where OUT_PORT is 1; an edge on the same bit in the same cycle keeps the bit set.
REQ-015 active = pending & mask; pending bits latch regardless of mask.
REQ-016 IN_PORT = {0, mask} at MASK_ID; {0, pending} at STATUS_ID; {|active, 4'b0, idx[2:0]} at VECTOR_ID, where idx is the lowest-numbered active bit (fixed priority, bit 0 highest), 0 when none; 8'h00 at any other ID.
REQ-017 Unused upper bits (index >= NUM_SRC) read 0 and ignore writes.
REQ-018 FSM states: IDLE, ASSERT, HOLDOFF; INTR = 1 only in ASSERT.
REQ-019 IDLE -> ASSERT when |active; INTR rises on the edge after active becomes nonzero (1-cycle latency from pending to INTR).
REQ-020 ASSERT -> HOLDOFF on any write to ACK_ID; ASSERT -> IDLE if active becomes 0 without an ACK (e.g. mask write).
REQ-021 HOLDOFF holds INTR low for exactly GAP_CYCLES cycles, then -> IDLE; new edges latch into pending during HOLDOFF and cause re-assertion from IDLE.
REQ-022 Writes to unlisted IDs, and reads, do not change state.

Reset
REQ-023 RST_N low asynchronously sets mask=0, pending=0, src_q=0, holdoff counter=0, state=IDLE, INTR=0.
REQ-024 Reset mid-ASSERT or mid-HOLDOFF drops INTR within the same reset assertion; the first cycle after release treats SRC levels already high as non-edges only if src_q captured them (src_q=0 so high SRC produces an edge).

Structure
REQ-025 Port ID constants and the FSM state enum reside in shared package rat_io_pkg, also used by the wrapper.
REQ-026 Priority encoder is sub-module rat_prio_enc (NUM_SRC-bit vector in, valid + 3-bit index out).
REQ-027 Wrapper ORs IN_PORT into its input mux and drives the MCU INTR input from INTR.

Verification
REQ-028 mask=8'h00, pulse SRC[3] -> STATUS reads 8'h08, INTR stays 0; then write MASK 8'h08 -> INTR=1 one cycle later, VECTOR reads 8'h83.
REQ-029 mask=8'hFF, edges on SRC[5] and SRC[2] same cycle -> VECTOR 8'h82; write ACK 8'h04 -> INTR low 4 cycles, re-asserts, VECTOR 8'h85.
REQ-030 SRC[1] held high 20 cycles -> pending sets once; after ACK 8'h02, pending[1] stays 0 while SRC[1] stays high.
REQ-031 Edge on SRC[0] in same cycle as ACK 8'h01 -> STATUS bit 0 remains 1.
REQ-032 INTR=1, mask write 8'h00 -> INTR=0 next cycle, state IDLE, pending unchanged.
REQ-033 RST_N low during HOLDOFF with pending 8'h10 -> INTR=0, STATUS 8'h00, MASK 8'h00 immediately.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared definitions for the interrupt controller and its MCU wrapper:
// I/O port addresses, controller FSM states and a write-decode helper.
package rat_io_pkg;

    localparam logic [7:0] MASK_ID   = 8'h50;
    localparam logic [7:0] STATUS_ID = 8'h51;
    localparam logic [7:0] VECTOR_ID = 8'h52;
    localparam logic [7:0] ACK_ID    = 8'h53;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } rat_state_e;

    // True when the MCU strobes a write to the given port address this cycle.
    function automatic logic port_write(input logic       strb,
                                        input logic [7:0] port_id,
                                        input logic [7:0] target_id);
        return strb & (port_id == target_id);
    endfunction

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// Bus bundle between the MCU-side wrapper and the interrupt controller:
// request lines, the MCU output-port write bus, read data and INTR.
interface rat_intr_ctrl_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] src;
    logic [7:0]         port_id;
    logic [7:0]         out_port;
    logic               io_strb;
    logic [7:0]         in_port;
    logic               intr;

    // MCU / wrapper side drives the bus and request lines.
    modport master (
        output src,
        output port_id,
        output out_port,
        output io_strb,
        input  in_port,
        input  intr
    );

    // Controller side.
    modport slave (
        input  src,
        input  port_id,
        input  out_port,
        input  io_strb,
        output in_port,
        output intr
    );
endinterface

// File: rtl/rat_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the lowest-numbered set bit (bit 0 wins). Index is 0 when nothing is set.
module rat_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] vec_i,
    output logic               valid_o,
    output logic [2:0]         idx_o
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        valid_o = |vec_i;
        idx_o   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 3'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller for the MCU: edge-detects up to eight request lines,
// latches them as pending, gates them with a mask and raises a single INTR
// with fixed-priority vector readback. After an acknowledge, INTR is held
// low for a minimum gap before it may re-assert.
module rat_intr_ctrl
    import rat_io_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rat_intr_ctrl_if.slave   bus
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mask_d;
    logic [NUM_SRC-1:0] src_edge_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [NUM_SRC-1:0] active_s;
    logic               mask_wr_s;
    logic               ack_wr_s;
    logic               prio_valid_s;
    logic [2:0]         prio_idx_s;
    logic [7:0]         mask_ext_s;
    logic [7:0]         pend_ext_s;
    rat_state_e         state_q;
    rat_state_e         state_d;
    logic [3:0]         hold_cnt_q;
    logic [3:0]         hold_cnt_d;
    logic               intr_q;

    // Write decode, edge detection and next values of the pending/mask registers.
    always_comb begin
        mask_wr_s  = port_write(bus.io_strb, bus.port_id, MASK_ID);
        ack_wr_s   = port_write(bus.io_strb, bus.port_id, ACK_ID);
        src_edge_s = bus.src & ~src_q;
        if (ack_wr_s) begin
            ack_clr_s = bus.out_port[NUM_SRC-1:0];
        end else begin
            ack_clr_s = {NUM_SRC{1'b0}};
        end
        // A new edge on a bit being acknowledged wins, so the request is not lost.
        pending_d = (pending_q & ~ack_clr_s) | src_edge_s;
        if (mask_wr_s) begin
            mask_d = bus.out_port[NUM_SRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        active_s = pending_q & mask_q;
    end

    // Source sampling, pending latch and mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= {NUM_SRC{1'b0}};
            pending_q <= {NUM_SRC{1'b0}};
            mask_q    <= {NUM_SRC{1'b0}};
        end else begin
            src_q     <= bus.src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    rat_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .vec_i   (active_s),
        .valid_o (prio_valid_s),
        .idx_o   (prio_idx_s)
    );

    // INTR sequencing: raise on active requests, drop on acknowledge into a
    // fixed-length hold-off, or drop straight to idle if masking removes the cause.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|active_s) begin
                    state_d = ST_ASSERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (ack_wr_s) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = GAP_LOAD;
                end else if (!(|active_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ASSERT;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    // State, hold-off counter and the registered INTR output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 4'd0;
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            intr_q     <= (state_d == ST_ASSERT);
        end
    end

    // Zero-extend mask/pending to the 8-bit read bus; unused bits read 0.
    always_comb begin
        mask_ext_s = 8'h00;
        pend_ext_s = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            mask_ext_s[i] = mask_q[i];
            pend_ext_s[i] = pending_q[i];
        end
    end

    // Read mux toward the wrapper; non-matching IDs contribute 0 to its OR.
    always_comb begin
        case (bus.port_id)
            MASK_ID:   bus.in_port = mask_ext_s;
            STATUS_ID: bus.in_port = pend_ext_s;
            VECTOR_ID: bus.in_port = {prio_valid_s, 4'b0000, prio_idx_s};
            default:   bus.in_port = 8'h00;
        endcase
    end

    assign bus.intr = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios plus a random
// run, all compared against a request/ack behavioural model.
module tb_rat_intr_ctrl;

    localparam int         NSRC   = 8;
    localparam int         GAP    = 4;
    localparam logic [7:0] P_MASK = 8'h50;
    localparam logic [7:0] P_STAT = 8'h51;
    localparam logic [7:0] P_VEC  = 8'h52;
    localparam logic [7:0] P_ACK  = 8'h53;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic       m_intr;
    int         m_gap;

    rat_intr_ctrl_if #(.NUM_SRC(NSRC)) tif ();

    rat_intr_ctrl #(
        .NUM_SRC    (NSRC),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_prev = 8'h00; m_pend = 8'h00; m_mask = 8'h00; m_intr = 1'b0; m_gap = 0;
    endtask

    // One clock of the controller's rules, from the inputs present at the edge.
    task automatic model_step();
        logic [7:0] act;
        logic       ack;
        logic       mw;
        act = m_pend & m_mask;
        ack = tif.io_strb && (tif.port_id == P_ACK);
        mw  = tif.io_strb && (tif.port_id == P_MASK);
        if (m_intr) begin
            if (ack) begin
                m_intr = 1'b0;
                m_gap  = GAP;
            end else if (act == 8'h00) begin
                m_intr = 1'b0;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else begin
            m_intr = (act != 8'h00);
        end
        m_pend = (m_pend & ~(ack ? tif.out_port : 8'h00)) | (tif.src & ~m_prev);
        m_prev = tif.src;
        if (mw) m_mask = tif.out_port;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] id);
        logic [7:0] act;
        logic [7:0] v;
        act = m_pend & m_mask;
        v = 8'h00;
        if (id == P_MASK) v = m_mask;
        else if (id == P_STAT) v = m_pend;
        else if (id == P_VEC) begin
            for (int i = 7; i >= 0; i--) if (act[i]) v = {1'b1, 4'b0000, 3'(i)};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] d);
        tif.port_id = id;
        #1;
        d = tif.in_port;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        tif.port_id  = id;
        tif.out_port = data;
        tif.io_strb  = 1'b1;
        tick();
        tif.io_strb  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        #15;
        checks++; if (tif.intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", tif.intr); end
        rd(P_MASK, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h expected 00", d); end
        rd(P_STAT, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", d); end
        rd(P_VEC, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h expected 00", d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mask_gate();
        logic [7:0] d;
        do_reset();
        wr(P_MASK, 8'h00);
        tif.src = 8'h08; tick(); tif.src = 8'h00; tick();
        rd(P_STAT, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL gate_status: got %h expected 08", d); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tif.intr !== 1'b0) begin errors++; $display("FAIL gate_intr_masked: got %b expected 0", tif.intr); end
        end
        wr(P_MASK, 8'h08);
        checks++; if (tif.intr !== 1'b0) begin errors++; $display("FAIL gate_intr_latency: got %b expected 0", tif.intr); end
        tick();
        checks++; if (tif.intr !== 1'b1) begin errors++; $display("FAIL gate_intr_rise: got %b expected 1", tif.intr); end
        rd(P_VEC, d);
        checks++; if (d !== 8'h83) begin errors++; $display("FAIL gate_vector: got %h expected 83", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        int n;
        do_reset();
        wr(P_MASK, 8'hFF);
        tif.src = 8'h24; tick(); tif.src = 8'h00; tick();
        checks++; if (tif.intr !== 1'b1) begin errors++; $display("FAIL prio_intr: got %b expected 1", tif.intr); end
        rd(P_VEC, d);
        checks++; if (d !== 8'h82) begin errors++; $display("FAIL prio_vector: got %h expected 82", d); end
        wr(P_ACK, 8'h04);
        n = 0;
        while (tif.intr === 1'b0 && n < 30) begin
            tick();
            n++;
        end
        // GAP hold-off cycles, then one idle cycle before re-assertion.
        checks++; if (n !== GAP + 1) begin errors++; $display("FAIL prio_gap_cycles: got %0d expected %0d", n, GAP + 1); end
        rd(P_VEC, d);
        checks++; if (d !== 8'h85) begin errors++; $display("FAIL prio_vector_after_ack: got %h expected 85", d); end
    endtask

    task automatic test_level();
        logic [7:0] d;
        do_reset();
        wr(P_MASK, 8'hFF);
        tif.src = 8'h02;
        for (int i = 0; i < 20; i++) tick();
        rd(P_STAT, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL level_status: got %h expected 02", d); end
        wr(P_ACK, 8'h02);
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(P_STAT, d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL level_no_repend: got %h expected 00", d); end
        end
        tif.src = 8'h00;
        tick();
    endtask

    task automatic test_ack_race();
        logic [7:0] d;
        do_reset();
        wr(P_MASK, 8'hFF);
        tif.src = 8'h01; tick(); tif.src = 8'h00; tick();
        tif.src = 8'h01;
        wr(P_ACK, 8'h01);
        rd(P_STAT, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL race_status: got %h expected 01", d); end
        tif.src = 8'h00;
        wr(P_ACK, 8'h01);
        rd(P_STAT, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL race_plain_ack: got %h expected 00", d); end
    endtask

    task automatic test_mask_drop();
        logic [7:0] d;
        do_reset();
        wr(P_MASK, 8'hFF);
        tif.src = 8'h30; tick(); tif.src = 8'h00; tick();
        checks++; if (tif.intr !== 1'b1) begin errors++; $display("FAIL drop_intr_pre: got %b expected 1", tif.intr); end
        wr(P_MASK, 8'h00);
        tick();
        checks++; if (tif.intr !== 1'b0) begin errors++; $display("FAIL drop_intr: got %b expected 0", tif.intr); end
        rd(P_STAT, d);
        checks++; if (d !== 8'h30) begin errors++; $display("FAIL drop_status: got %h expected 30", d); end
        // From idle (no hold-off) unmasking re-asserts after one cycle.
        wr(P_MASK, 8'hFF);
        tick();
        checks++; if (tif.intr !== 1'b1) begin errors++; $display("FAIL drop_idle_reassert: got %b expected 1", tif.intr); end
    endtask

    task automatic test_reset_holdoff();
        logic [7:0] d;
        do_reset();
        wr(P_MASK, 8'hFF);
        tif.src = 8'h11; tick(); tif.src = 8'h00; tick();
        wr(P_ACK, 8'h01);
        tick();
        rd(P_STAT, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL rsthold_pre_status: got %h expected 10", d); end
        #3;
        rst_n = 1'b0;
        model_reset();
        tif.src = 8'h01;
        #1;
        checks++; if (tif.intr !== 1'b0) begin errors++; $display("FAIL rsthold_intr: got %b expected 0", tif.intr); end
        rd(P_STAT, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rsthold_status: got %h expected 00", d); end
        rd(P_MASK, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rsthold_mask: got %h expected 00", d); end
        @(negedge clk);
        rst_n = 1'b1;
        wr(P_MASK, 8'hFF);
        rd(P_STAT, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL rsthold_level_edge: got %h expected 01", d); end
        tif.src = 8'h00;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] ids [3];
        ids[0] = P_MASK; ids[1] = P_STAT; ids[2] = P_VEC;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tif.src = (($urandom_range(0, 3) == 0) ? 8'($urandom) : tif.src);
            case ($urandom_range(0, 7))
                0: begin tif.io_strb = 1'b1; tif.port_id = P_MASK; tif.out_port = 8'($urandom); end
                1, 2: begin tif.io_strb = 1'b1; tif.port_id = P_ACK; tif.out_port = 8'($urandom); end
                3: begin tif.io_strb = 1'b1; tif.port_id = 8'($urandom_range(8'h54, 8'hFF)); tif.out_port = 8'($urandom); end
                default: tif.io_strb = 1'b0;
            endcase
            tick();
            tif.io_strb = 1'b0;
            checks++; if (tif.intr !== m_intr) begin errors++; $display("FAIL rand_intr cyc %0d: got %b expected %b", c, tif.intr, m_intr); end
            for (int k = 0; k < 3; k++) begin
                rd(ids[k], d);
                checks++; if (d !== model_read(ids[k])) begin errors++; $display("FAIL rand_read id %h cyc %0d: got %h expected %h", ids[k], c, d, model_read(ids[k])); end
            end
        end
    endtask

    initial begin
        tif.src = 8'h00; tif.port_id = 8'h00; tif.out_port = 8'h00; tif.io_strb = 1'b0;
        model_reset();
        test_reset();
        test_mask_gate();
        test_priority();
        test_level();
        test_ack_race();
        test_mask_drop();
        test_reset_holdoff();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
